// File: rtl/intt_sched_if.sv
// Sequencer-to-datapath bundle for the inverse NTT engine: start/done handshake,
// coefficient memory read/write ports, twiddle index and butterfly mode.
interface intt_sched_if;
  logic       start_NTT;
  logic       done_NTT;
  logic       busy;
  logic       rd_en;
  logic [7:0] rd_addr0;
  logic [7:0] rd_addr1;
  logic [7:0] tw_idx;
  logic       bf_mode;
  logic       wr_en;
  logic [7:0] wr_addr0;
  logic [7:0] wr_addr1;
  logic [3:0] stage;

  modport master (
    input  start_NTT,
    output done_NTT, busy, rd_en, rd_addr0, rd_addr1, tw_idx, bf_mode,
           wr_en, wr_addr0, wr_addr1, stage
  );

  modport slave (
    output start_NTT,
    input  done_NTT, busy, rd_en, rd_addr0, rd_addr1, tw_idx, bf_mode,
           wr_en, wr_addr0, wr_addr1, stage
  );
endinterface

// File: rtl/intt_sched.sv
// Stage sequencer / address generator for the 256-point Dilithium inverse NTT.
// Define INTT_SCALE_EN to append the n^-1 scaling pass (stage 8) after stage 7.
//
// state | meaning
// IDLE  | waiting for start_NTT
// RUN   | one butterfly (or scale pair) read per cycle, b = 0..127
// DRAIN | PIPE_LAT cycles with no reads so the stage's writes land first
// DONE  | single-cycle done_NTT pulse
module intt_sched #(
  parameter int PIPE_LAT = 4,
  parameter int N_LOG    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  intt_sched_if.master bus
);
  localparam int         HALF        = 1 << (N_LOG - 1);
  localparam logic [6:0] B_LAST      = 7'(HALF - 1);
  localparam logic [3:0] DRAIN_INIT  = 4'(PIPE_LAT - 1);
  localparam logic [3:0] SCALE_STAGE = 4'd8;
`ifdef INTT_SCALE_EN
  localparam logic [3:0] LAST_STAGE  = 4'd8;
`else
  localparam logic [3:0] LAST_STAGE  = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state, state_nxt;
  logic [6:0] b, b_nxt;
  logic [3:0] stage_q, stage_nxt;
  logic [3:0] dcnt, dcnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      b       <= '0;
      stage_q <= '0;
      dcnt    <= '0;
    end else begin
      state   <= state_nxt;
      b       <= b_nxt;
      stage_q <= stage_nxt;
      dcnt    <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    stage_nxt = stage_q;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (bus.start_NTT) begin
          state_nxt = RUN;
          b_nxt     = '0;
          stage_nxt = '0;
        end
      end
      RUN: begin
        b_nxt = b + 7'd1;
        if (b == B_LAST) begin
          state_nxt = DRAIN;
          dcnt_nxt  = DRAIN_INIT;
          b_nxt     = '0;
        end
      end
      DRAIN: begin
        if (dcnt == 4'd0) begin
          if (stage_q == LAST_STAGE) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage_q + 4'd1;
          end
        end else begin
          dcnt_nxt = dcnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        stage_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address split: g = group, o = offset inside group, len = 1 << s.
  logic [2:0] s;
  logic [7:0] len, g, o, ad0, ad1, tw;
  logic       rd_en_c, is_scale;

  always_comb begin
    s        = stage_q[2:0];
    len      = 8'd1 << s;
    g        = {1'b0, b} >> s;
    o        = {1'b0, b} & (len - 8'd1);
    ad0      = (g << ({1'b0, s} + 4'd1)) + o;
    ad1      = ad0 + len;
    tw       = 8'((9'd256 >> s) - 9'd1) - g;
    rd_en_c  = (state == RUN);
    is_scale = (stage_q == SCALE_STAGE);
  end

  logic       wr_sr  [PIPE_LAT];
  logic [7:0] wa0_sr [PIPE_LAT];
  logic [7:0] wa1_sr [PIPE_LAT];

  // Runs every cycle (including DRAIN); cleared on reset so no stale write escapes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_sr[i]  <= 1'b0;
        wa0_sr[i] <= '0;
        wa1_sr[i] <= '0;
      end
    end else begin
      wr_sr[0]  <= rd_en_c;
      wa0_sr[0] <= bus.rd_addr0;
      wa1_sr[0] <= bus.rd_addr1;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_sr[i]  <= wr_sr[i-1];
        wa0_sr[i] <= wa0_sr[i-1];
        wa1_sr[i] <= wa1_sr[i-1];
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done_NTT = (state == DONE);
  assign bus.stage    = stage_q;
  assign bus.rd_en    = rd_en_c;
  assign bus.rd_addr0 = !rd_en_c ? 8'd0 : (is_scale ? {b, 1'b0} : ad0);
  assign bus.rd_addr1 = !rd_en_c ? 8'd0 : (is_scale ? {b, 1'b1} : ad1);
  assign bus.tw_idx   = (rd_en_c && !is_scale) ? tw : 8'd0;
  assign bus.bf_mode  = rd_en_c && is_scale;
  assign bus.wr_en    = wr_sr[PIPE_LAT-1];
  assign bus.wr_addr0 = wa0_sr[PIPE_LAT-1];
  assign bus.wr_addr1 = wa1_sr[PIPE_LAT-1];
endmodule

// File: tb/tb_intt_sched.sv
// Directed bench for intt_sched: cycle-indexed capture of a full run, checked against
// hand-computed vectors, plus restart, mid-run reset and PIPE_LAT = 1 sequences.
module tb_intt_sched;
  localparam int MAXC = 1300;
`ifdef INTT_SCALE_EN
  localparam int NST = 9;
`else
  localparam int NST = 8;
`endif
  localparam int DONE4 = NST * 132 + 1;
  localparam int DONE1 = NST * 129 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  intt_sched_if bus4();
  intt_sched_if bus1();

  intt_sched #(.PIPE_LAT(4), .N_LOG(8)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus4.master));
  intt_sched #(.PIPE_LAT(1), .N_LOG(8)) dut_p1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [48:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [48:0] c_vec [MAXC];
  logic        c_rd  [MAXC];
  logic        c_wr  [MAXC];
  logic        c_done[MAXC];
  logic        c_busy[MAXC];
  logic [3:0]  c_stg [MAXC];
  logic [7:0]  c_a0  [MAXC];
  logic [7:0]  c_a1  [MAXC];
  logic        p_rd  [MAXC];
  logic        p_done[MAXC];
  logic [3:0]  p_stg [MAXC];

  function automatic logic [48:0] mk(logic rd, logic [7:0] a0, logic [7:0] a1, logic [7:0] tw,
                                     logic bf, logic wr, logic [7:0] wa0, logic [7:0] wa1,
                                     logic [3:0] stg, logic done, logic busy);
    return {rd, a0, a1, tw, bf, wr, wa0, wa1, stg, done, busy};
  endfunction

  function automatic logic [48:0] live4();
    return mk(bus4.rd_en, bus4.rd_addr0, bus4.rd_addr1, bus4.tw_idx, bus4.bf_mode, bus4.wr_en,
              bus4.wr_addr0, bus4.wr_addr1, bus4.stage, bus4.done_NTT, bus4.busy);
  endfunction

  function automatic logic [48:0] live1();
    return mk(bus1.rd_en, bus1.rd_addr0, bus1.rd_addr1, bus1.tw_idx, bus1.bf_mode, bus1.wr_en,
              bus1.wr_addr0, bus1.wr_addr1, bus1.stage, bus1.done_NTT, bus1.busy);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Records cycle k (the period before edge k) and drives the inputs sampled at edge k.
  task automatic capture(int n, bit hold, int pulse_at, int rst_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      c_vec[k]  = live4();
      c_rd[k]   = bus4.rd_en;
      c_wr[k]   = bus4.wr_en;
      c_done[k] = bus4.done_NTT;
      c_busy[k] = bus4.busy;
      c_stg[k]  = bus4.stage;
      c_a0[k]   = bus4.rd_addr0;
      c_a1[k]   = bus4.rd_addr1;
      p_rd[k]   = bus1.rd_en;
      p_done[k] = bus1.done_NTT;
      p_stg[k]  = bus1.stage;
      bus4.start_NTT = hold || (k == pulse_at);
      bus1.start_NTT = 1'b0;
      rst_n = (k != rst_at);
      @(posedge clk);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int rd_cnt, wr_cnt, done_cnt, done_cyc, max_stg, haz, last_wr, p_first1, p_done_cyc, cnt;
    int first_rd[16];

    vecs.push_back('{1,    mk(1, 0,   1,   255, 0, 0, 0,   0,   0, 0, 1)});
    vecs.push_back('{2,    mk(1, 2,   3,   254, 0, 0, 0,   0,   0, 0, 1)});
    vecs.push_back('{5,    mk(1, 8,   9,   251, 0, 1, 0,   1,   0, 0, 1)});
    vecs.push_back('{128,  mk(1, 254, 255, 128, 0, 1, 246, 247, 0, 0, 1)});
    vecs.push_back('{129,  mk(0, 0,   0,   0,   0, 1, 248, 249, 0, 0, 1)});
    vecs.push_back('{132,  mk(0, 0,   0,   0,   0, 1, 254, 255, 0, 0, 1)});
    vecs.push_back('{133,  mk(1, 0,   2,   127, 0, 0, 0,   0,   1, 0, 1)});
    vecs.push_back('{270,  mk(1, 9,   13,  62,  0, 1, 1,   5,   2, 0, 1)});
    vecs.push_back('{406,  mk(1, 17,  25,  30,  0, 1, 5,   13,  3, 0, 1)});
    vecs.push_back('{925,  mk(1, 0,   128, 1,   0, 0, 0,   0,   7, 0, 1)});
    vecs.push_back('{1052, mk(1, 127, 255, 1,   0, 1, 123, 251, 7, 0, 1)});
    vecs.push_back('{1056, mk(0, 0,   0,   0,   0, 1, 127, 255, 7, 0, 1)});
`ifdef INTT_SCALE_EN
    vecs.push_back('{1057, mk(1, 0,   1,   0,   1, 0, 0,   0,   8, 0, 1)});
    vecs.push_back('{1184, mk(1, 254, 255, 0,   1, 1, 246, 247, 8, 0, 1)});
    vecs.push_back('{1188, mk(0, 0,   0,   0,   0, 1, 254, 255, 8, 0, 1)});
    vecs.push_back('{1189, mk(0, 0,   0,   0,   0, 0, 0,   0,   8, 1, 1)});
    vecs.push_back('{1190, mk(0, 0,   0,   0,   0, 0, 0,   0,   0, 0, 0)});
`else
    vecs.push_back('{1057, mk(0, 0,   0,   0,   0, 0, 0,   0,   7, 1, 1)});
    vecs.push_back('{1058, mk(0, 0,   0,   0,   0, 0, 0,   0,   0, 0, 0)});
`endif

    bus4.start_NTT = 1'b0;
    bus1.start_NTT = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_lat4", 64'(live4()), 64'd0);
    check("reset_outputs_lat1", 64'(live1()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Main run on both instances; start re-pulsed at cycle 500 must be ignored.
    bus4.start_NTT = 1'b1;
    bus1.start_NTT = 1'b1;
    @(posedge clk);
    capture(1200, 1'b0, 500, -1);

    foreach (vecs[i])
      check($sformatf("vector_cycle_%0d", vecs[i].cyc), 64'(c_vec[vecs[i].cyc]), 64'(vecs[i].exp));

    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; max_stg = 0; haz = 0;
    p_first1 = -1; p_done_cyc = -1;
    for (int s = 0; s < 16; s++) first_rd[s] = -1;
    for (int k = 1; k <= 1200; k++) begin
      rd_cnt   += int'(c_rd[k]);
      wr_cnt   += int'(c_wr[k]);
      done_cnt += int'(c_done[k]);
      if (c_done[k]) done_cyc = k;
      if (int'(c_stg[k]) > max_stg) max_stg = int'(c_stg[k]);
      if (c_rd[k] && first_rd[c_stg[k]] < 0) first_rd[c_stg[k]] = k;
      if (p_rd[k] && p_stg[k] == 4'd1 && p_first1 < 0) p_first1 = k;
      if (p_done[k] && p_done_cyc < 0) p_done_cyc = k;
      if (c_rd[k]) begin
        for (int d = 1; d <= 4; d++) begin
          if (k - d >= 1 && c_rd[k-d] && c_stg[k-d] != c_stg[k] &&
              (c_a0[k-d] == c_a0[k] || c_a0[k-d] == c_a1[k] ||
               c_a1[k-d] == c_a0[k] || c_a1[k-d] == c_a1[k]))
            haz++;
        end
      end
    end
    check("rd_en_count", rd_cnt, NST * 128);
    check("wr_en_count", wr_cnt, NST * 128);
    check("done_pulse_count", done_cnt, 1);
    check("done_cycle", done_cyc, DONE4);
    check("max_stage", max_stg, NST - 1);
    check("raw_hazards", haz, 0);
    for (int s = 1; s < NST; s++) begin
      last_wr = -1;
      for (int k = 1; k < first_rd[s]; k++)
        if (c_wr[k]) last_wr = k;
      check($sformatf("stage%0d_first_read", s), first_rd[s], 1 + s * 132);
      check($sformatf("stage%0d_raw_gap", s), last_wr + 1, first_rd[s]);
    end
    check("lat1_stage1_start", p_first1, 130);
    check("lat1_done_cycle", p_done_cyc, DONE1);

    // Reset mid-run at edge 600: everything quiet afterwards, no stray writes.
    @(negedge clk);
    bus4.start_NTT = 1'b1;
    @(posedge clk);
    capture(610, 1'b0, -1, 600);
    check("running_before_reset", 64'(c_rd[599]), 64'd1);
    check("outputs_after_reset", 64'(c_vec[601]), 64'd0);
    cnt = 0;
    for (int k = 601; k <= 610; k++) cnt += int'(c_wr[k]) + int'(c_busy[k]);
    check("no_activity_after_reset", cnt, 0);

    // start held high: a second run begins straight from IDLE after DONE.
    @(negedge clk);
    bus4.start_NTT = 1'b1;
    @(posedge clk);
    capture(1200, 1'b1, -1, -1);
    check("held_start_done", 64'(c_done[DONE4]), 64'd1);
    check("held_start_idle_gap", 64'(c_busy[DONE4 + 1]), 64'd0);
    check("held_start_restart", 64'(c_vec[DONE4 + 2]),
          64'(mk(1, 0, 1, 255, 0, 0, 0, 0, 0, 0, 1)));
    bus4.start_NTT = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
